issue_ctrl: RTL and testbench
=============================

# issue_ctrl

Parametrised, credit-based N-way issue stage between the resolver and the reservation stations / reorder buffer. It tracks free slots per destination unit with counters instead of consuming fullness flags, and issues the longest in-order prefix of an instruction bundle that fits. Any unissued tail is held and replayed while upstream is stalled. Outputs are registered; `stop` stalls the loader, decoder and resolver.

## Interface
- `XLEN`, 32: data/address width carried by `instr_info_bus_if`
- `WAYS`, 2: instructions per bundle (1..4)
- `AL_DEPTH`, 8: ALU station entries
- `BR_DEPTH`, 4: branch station entries
- `LS_DEPTH`, 8: load/store station entries
- `MD_DEPTH`, 4: mult/div station entries
- `RB_DEPTH`, 32: reorder buffer entries
- `global_bus.clock`  in  1  sole clock; all state on rising edge
- `global_bus.reset`  in  1  synchronous, active-high
- `flush`  in  1  pipeline flush (mispredict); synchronous
- `instr_info_in[WAYS]`  in  bundle  way 0 oldest; `instr_name == UNKNOWN` marks an empty way
- `instr_info_out[WAYS]`  out  bundle  issued instructions in their original way slot; `UNKNOWN` = bubble
- `release[UNIT_COUNT]`  in  UNIT_COUNT x $clog2(WAYS+1)  slots freed this cycle per unit (AL, BR, LS, RB, MD)
- `stop`  out  1  upstream must hold `instr_info_in` stable

## Operation
- Credits: one counter per unit, width $clog2(depth+1). Reset and flush load each counter with its `*_DEPTH`.
- Candidate bundle:
  - the hold register when any hold way is valid;
  - otherwise `instr_info_in`, which is ignored while `stop` = 1.
- Demand:
  - each valid way consumes 1 credit of its `instr_type` and 1 RB credit;
  - ways are scanned 0..WAYS-1 and cumulative per-unit demand is compared against current credits;
  - way k issues only if ways 0..k all fit. The first non-fitting valid way blocks itself and every later way, even if a later way would fit.
  - Empty ways neither consume credits nor block.
- Issue: each issued way is copied into `instr_info_out[k]` (address, immediate, instr_name, instr_type, regs, flags). Non-issued slots are driven `UNKNOWN`.
- Hold:
  - unissued valid ways stay in the hold register at their original index;
  - issued slots in the hold become `UNKNOWN`;
  - when nothing remains, the hold is cleared.
- Credit update: credit_next = credit − issued + release. A release only becomes usable in the following cycle. Credit never exceeds depth or goes below 0 (assertion, not saturation).
- `stop` = 1 while any hold way is valid; it is registered from hold state.
- Flush:
  - clears the hold, output slots and `stop`;
  - credits return to depth;
  - `release` in the same cycle is ignored;
  - a bundle present in the flush cycle is dropped.
- Reset has priority over flush. Reset value of every output: `instr_info_out[*].instr_name` = `UNKNOWN`, all other output fields 0, `stop` = 0.

## Timing
- Latency: input to `instr_info_out` is 1 cycle.
- `stop` rises the cycle after a partial or zero issue. It falls the cycle after the hold drains, and a new bundle is accepted in that cycle.
- A zero-credit unit keeps the whole bundle held, with `stop` = 1, until a release arrives.
- The earliest issue after a release is 1 cycle later; re-issue happens the cycle after the release edge.
- Issue and release in the same cycle on the same unit: both apply; net change = release − issued.
- All-`UNKNOWN` input: no issue, no credit change, `stop` unchanged (0).

## Structure
- `structures` package:
  - existing `instr_type` enum (AL, BR, LS, RB, MD);
  - add `UNIT_COUNT` = 5;
  - add the per-unit depth-to-width function `credit_w(depth)`.
- Sub-module `credit_counter` (params DEPTH, IN_W): instantiated per unit; ports inc/dec/reload/count.
- The in-order prefix scan is a generate loop of cumulative adders in `issue_ctrl`.

## Test plan
- Reset, then bundle {ADD (AL), BEQ (BR)} with full credits -> both issue the next cycle; AL credit 8→7, BR 4→3, RB 32→30; `stop` stays 0.
- BR credit = 0, bundle {BEQ, ADD} -> nothing issues; `stop` = 1. `release[BR]` = 1 -> BEQ and ADD issue the cycle after next; `stop` returns to 0.
- AL credit = 1, bundle {ADD, SUB} -> way 0 ADD issues and way 1 is held; `stop` = 1. `release[AL]` = 1 -> SUB issues in way 1, way 0 `UNKNOWN`.
- RB credit = 1, bundle {LW, ADD} -> only LW issues. Way 0 `UNKNOWN` plus way 1 ADD, with no RB credit -> no issue and no credit change.
- Hold non-empty and `flush` = 1 with `release[LS]` = 2 -> the next cycle has hold empty, outputs `UNKNOWN`, `stop` = 0, all credits at depth.
- `reset` asserted mid-stall with `flush` also high -> reset values on all outputs; a bundle presented the following cycle issues normally.

Source files
------------

// File: rtl/structures.sv
// Shared types for the issue stage.
//   instr_type_t : destination unit of an instruction. Its encoding doubles as the
//                  credit unit index (AL, BR, LS, RB, MD).
//   instr_name_t : opcode mnemonic. UNKNOWN (all zeros) marks an empty way or a bubble.
//   instr_info_t : one bundle way as carried on the instruction info bus.
//   credit_w()   : width of a credit counter that must hold 0..depth.
//   unit_mask()  : the set of credit units one valid instruction consumes.
package structures;

    localparam int INFO_XLEN  = 32;
    localparam int UNIT_COUNT = 5;

    typedef enum logic [2:0] {
        AL = 3'd0,
        BR = 3'd1,
        LS = 3'd2,
        RB = 3'd3,
        MD = 3'd4
    } instr_type_t;

    typedef enum logic [3:0] {
        UNKNOWN = 4'd0,
        ADD     = 4'd1,
        SUB     = 4'd2,
        BEQ     = 4'd3,
        BNE     = 4'd4,
        LW      = 4'd5,
        SW      = 4'd6,
        MUL     = 4'd7,
        DIV     = 4'd8
    } instr_name_t;

    typedef struct packed {
        logic [INFO_XLEN-1:0] address;
        logic [INFO_XLEN-1:0] immediate;
        instr_name_t          instr_name;
        instr_type_t          instr_type;
        logic [4:0]           rd;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [3:0]           flags;
    } instr_info_t;

    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Every valid instruction takes one slot in its own unit plus one ROB entry.
    function automatic logic [UNIT_COUNT-1:0] unit_mask(input instr_type_t t);
        logic [UNIT_COUNT-1:0] m;
        m = '0;
        for (int u = 0; u < UNIT_COUNT; u++) begin
            if (t == instr_type_t'(u)) begin
                m[u] = 1'b1;
            end
        end
        m[int'(RB)] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Free-slot counter for one destination unit.
//   clock  : rising-edge clock
//   reset  : synchronous, active-high; loads DEPTH
//   reload : synchronous reload to DEPTH (flush); inc/dec ignored that cycle
//   inc    : slots released by the unit this cycle
//   dec    : slots consumed by issue this cycle
//   count  : current free slots, 0..DEPTH
module credit_counter
    import structures::*;
#(
    parameter int DEPTH = 8,
    parameter int IN_W  = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       reload,
    input  logic [IN_W-1:0]            inc,
    input  logic [IN_W-1:0]            dec,
    output logic [credit_w(DEPTH)-1:0] count
);

    localparam int W  = credit_w(DEPTH);
    // Two guard bits so an underflow wraps to a value above DEPTH and trips the check.
    localparam int NW = ((W > IN_W) ? W : IN_W) + 2;

    logic [NW-1:0] nxt;

    assign nxt = NW'(count) + NW'(inc) - NW'(dec);

    always_ff @(posedge clock) begin
        if (reset || reload) begin
            count <= W'(DEPTH);
        end else begin
            count <= nxt[W-1:0];
        end
    end

    // Credit accounting is exact: issue never overdraws and units never over-release.
    always_ff @(posedge clock) begin
        if (!reset && !reload) begin
            assert (nxt <= NW'(DEPTH));
        end
    end

endmodule

// File: rtl/issue_ctrl.sv
// Credit-based N-way issue stage between the resolver and the reservation
// stations / reorder buffer. Issues the longest in-order prefix of a bundle that
// fits the free slots, holds and replays the unissued tail while stalling upstream.
//   clock          : rising-edge clock
//   reset          : synchronous, active-high (priority over flush)
//   flush          : pipeline flush; drops hold and current bundle, restores credits
//   instr_info_in  : incoming bundle, way 0 oldest, UNKNOWN = empty way
//   instr_info_out : registered issued ways in their original slot, UNKNOWN = bubble
//   unit_release   : slots freed this cycle per unit (AL, BR, LS, RB, MD)
//   stop           : registered; upstream must hold instr_info_in stable
module issue_ctrl
    import structures::*;
#(
    parameter int XLEN     = 32,
    parameter int WAYS     = 2,
    parameter int AL_DEPTH = 8,
    parameter int BR_DEPTH = 4,
    parameter int LS_DEPTH = 8,
    parameter int MD_DEPTH = 4,
    parameter int RB_DEPTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  instr_info_t               instr_info_in  [WAYS],
    output instr_info_t               instr_info_out [WAYS],
    input  logic [credit_w(WAYS)-1:0] unit_release   [UNIT_COUNT],
    output logic                      stop
);

    localparam int IN_W  = credit_w(WAYS);
    localparam int CMP_W = 16;
    localparam int DEPTHS [UNIT_COUNT] = '{AL_DEPTH, BR_DEPTH, LS_DEPTH, RB_DEPTH, MD_DEPTH};

    if (XLEN != INFO_XLEN || WAYS < 1 || WAYS > 4) begin : g_param_check
        $error("issue_ctrl: XLEN must match the bus width and WAYS must be 1..4");
    end

    instr_info_t           hold   [WAYS];
    instr_info_t           cand   [WAYS];
    logic [CMP_W-1:0]      credit [UNIT_COUNT];
    logic [IN_W-1:0]       used   [UNIT_COUNT];
    logic [UNIT_COUNT-1:0] demand [WAYS];
    logic [WAYS-1:0]       valid;
    logic [WAYS-1:0]       blocks;
    logic [WAYS-1:0]       issue;
    logic                  hold_any;
    logic                  remaining;

    // The held tail always wins; a fresh bundle is only looked at once stop has dropped.
    always_comb begin
        hold_any = 1'b0;
        for (int k = 0; k < WAYS; k++) begin
            if (hold[k].instr_name != UNKNOWN) begin
                hold_any = 1'b1;
            end
        end
        for (int k = 0; k < WAYS; k++) begin
            if (hold_any) begin
                cand[k] = hold[k];
            end else if (stop) begin
                cand[k] = '0;
            end else begin
                cand[k] = instr_info_in[k];
            end
        end
    end

    // Per way: cumulative demand of ways 0..k against current credits. A valid way
    // that does not fit blocks itself and everything younger; empty ways are transparent.
    for (genvar k = 0; k < WAYS; k++) begin : g_way
        localparam logic [WAYS-1:0] OLDER = WAYS'((1 << k) - 1);

        logic [CMP_W-1:0] cum [UNIT_COUNT];
        logic             fit_k;

        assign valid[k]  = (cand[k].instr_name != UNKNOWN);
        assign demand[k] = valid[k] ? unit_mask(cand[k].instr_type) : '0;

        always_comb begin
            fit_k = 1'b1;
            for (int u = 0; u < UNIT_COUNT; u++) begin
                cum[u] = '0;
                for (int j = 0; j <= k; j++) begin
                    cum[u] = cum[u] + CMP_W'(demand[j][u]);
                end
                if (cum[u] > credit[u]) begin
                    fit_k = 1'b0;
                end
            end
        end

        assign blocks[k] = valid[k] & ~fit_k;
        assign issue[k]  = valid[k] & fit_k & ~|(blocks & OLDER);
    end

    always_comb begin
        for (int u = 0; u < UNIT_COUNT; u++) begin
            used[u] = '0;
            for (int k = 0; k < WAYS; k++) begin
                if (issue[k] && demand[k][u]) begin
                    used[u] = used[u] + IN_W'(1);
                end
            end
        end
    end

    assign remaining = |(valid & ~issue);

    for (genvar u = 0; u < UNIT_COUNT; u++) begin : g_unit
        logic [credit_w(DEPTHS[u])-1:0] count;

        credit_counter #(
            .DEPTH (DEPTHS[u]),
            .IN_W  (IN_W)
        ) u_credit (
            .clock  (clock),
            .reset  (reset),
            .reload (flush),
            .inc    (unit_release[u]),
            .dec    (used[u]),
            .count  (count)
        );

        assign credit[u] = CMP_W'(count);
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int k = 0; k < WAYS; k++) begin
                instr_info_out[k] <= '0;
                hold[k]           <= '0;
            end
            stop <= 1'b0;
        end else begin
            for (int k = 0; k < WAYS; k++) begin
                instr_info_out[k] <= issue[k] ? cand[k] : '0;
                hold[k]           <= (valid[k] && !issue[k]) ? cand[k] : '0;
            end
            stop <= remaining;
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl (WAYS = 2, default depths). Expected outputs and
// credit values are hand-derived per step.
module tb_issue_ctrl;
    import structures::*;

    localparam int WAYS = 2;
    localparam int IN_W = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        stop;
    instr_info_t bundle [WAYS];
    instr_info_t outs   [WAYS];
    logic [IN_W-1:0] rel [UNIT_COUNT];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    issue_ctrl #(
        .XLEN     (32),
        .WAYS     (WAYS),
        .AL_DEPTH (8),
        .BR_DEPTH (4),
        .LS_DEPTH (8),
        .MD_DEPTH (4),
        .RB_DEPTH (32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .instr_info_in  (bundle),
        .instr_info_out (outs),
        .unit_release   (rel),
        .stop           (stop)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic instr_info_t mk(input instr_name_t n, input instr_type_t t,
                                       input logic [31:0] a);
        instr_info_t r;
        r            = '0;
        r.instr_name = n;
        r.instr_type = t;
        r.address    = a;
        r.immediate  = a + 32'd16;
        r.rd         = 5'd3;
        r.rs1        = 5'd1;
        r.flags      = 4'h1;
        return r;
    endfunction

    task automatic put(input instr_info_t a, input instr_info_t b);
        bundle[0] = a;
        bundle[1] = b;
    endtask

    task automatic clear_rel();
        for (int u = 0; u < UNIT_COUNT; u++) rel[u] = '0;
    endtask

    task automatic chk_out(input string tag, input instr_name_t n0, input instr_name_t n1,
                           input logic s);
        chk({tag, ".out0"}, 64'(outs[0].instr_name), 64'(n0));
        chk({tag, ".out1"}, 64'(outs[1].instr_name), 64'(n1));
        chk({tag, ".stop"}, 64'(stop), 64'(s));
    endtask

    task automatic chk_cr(input string tag, input int al, input int br, input int ls,
                          input int rb, input int md);
        chk({tag, ".cr_al"}, 64'(dut.credit[0]), 64'(al));
        chk({tag, ".cr_br"}, 64'(dut.credit[1]), 64'(br));
        chk({tag, ".cr_ls"}, 64'(dut.credit[2]), 64'(ls));
        chk({tag, ".cr_rb"}, 64'(dut.credit[3]), 64'(rb));
        chk({tag, ".cr_md"}, 64'(dut.credit[4]), 64'(md));
    endtask

    instr_info_t e;

    initial begin
        e = '0;
        reset = 1'b1;
        flush = 1'b0;
        clear_rel();
        put(e, e);
        step();
        step();
        reset = 1'b0;
        chk_out("reset", UNKNOWN, UNKNOWN, 1'b0);
        chk_cr("reset", 8, 4, 8, 32, 4);

        // Empty bundle: nothing moves.
        step();
        chk_out("empty", UNKNOWN, UNKNOWN, 1'b0);
        chk_cr("empty", 8, 4, 8, 32, 4);

        // Full credits, both ways issue next cycle.
        put(mk(ADD, AL, 32'h100), mk(BEQ, BR, 32'h104));
        step();
        chk_out("dual", ADD, BEQ, 1'b0);
        chk("dual.addr0", 64'(outs[0].address), 64'h100);
        chk("dual.imm1", 64'(outs[1].immediate), 64'h114);
        chk("dual.type1", 64'(outs[1].instr_type), 64'(BR));
        chk_cr("dual", 7, 3, 8, 30, 4);
        put(e, e);
        step();
        chk_out("bubble", UNKNOWN, UNKNOWN, 1'b0);

        // Drain BR to zero, then {BEQ, ADD} must stall whole (ADD blocked behind BEQ).
        put(mk(BEQ, BR, 32'h110), mk(BEQ, BR, 32'h114));
        step();
        put(mk(BEQ, BR, 32'h118), e);
        step();
        chk_cr("br_drain", 7, 0, 8, 27, 4);
        put(mk(BEQ, BR, 32'h120), mk(ADD, AL, 32'h124));
        step();
        chk_out("br_zero", UNKNOWN, UNKNOWN, 1'b1);
        chk_cr("br_zero", 7, 0, 8, 27, 4);
        rel[int'(BR)] = 2'd1;
        step();
        clear_rel();
        chk_out("br_rel", UNKNOWN, UNKNOWN, 1'b1);
        chk_cr("br_rel", 7, 1, 8, 27, 4);
        step();
        put(e, e);
        chk_out("br_issue", BEQ, ADD, 1'b0);
        chk("br_issue.addr1", 64'(outs[1].address), 64'h124);
        chk_cr("br_issue", 6, 0, 8, 25, 4);

        // AL down to 1, {ADD, SUB}: ADD issues, SUB held.
        put(mk(ADD, AL, 32'h130), mk(ADD, AL, 32'h134));
        step();
        step();
        put(mk(ADD, AL, 32'h138), e);
        step();
        chk_cr("al_drain", 1, 0, 8, 20, 4);
        put(mk(ADD, AL, 32'h200), mk(SUB, AL, 32'h204));
        step();
        chk_out("al_part", ADD, UNKNOWN, 1'b1);
        chk_cr("al_part", 0, 0, 8, 19, 4);
        rel[int'(AL)] = 2'd1;
        step();
        clear_rel();
        chk_out("al_rel", UNKNOWN, UNKNOWN, 1'b1);
        chk_cr("al_rel", 1, 0, 8, 19, 4);
        step();
        put(e, e);
        chk_out("al_tail", UNKNOWN, SUB, 1'b0);
        chk("al_tail.addr1", 64'(outs[1].address), 64'h204);
        chk_cr("al_tail", 0, 0, 8, 18, 4);

        // Drain RB to 1 with LS recycling; issue and release on LS in the same cycle.
        for (int i = 0; i < 8; i++) begin
            put(mk(LW, LS, 32'h300), mk(LW, LS, 32'h304));
            rel[int'(LS)] = 2'd2;
            rel[int'(AL)] = (i == 0) ? 2'd2 : 2'd0;
            step();
        end
        chk_cr("rb_drain", 2, 0, 8, 2, 4);
        put(mk(LW, LS, 32'h308), e);
        rel[int'(AL)] = 2'd0;
        rel[int'(LS)] = 2'd1;
        step();
        clear_rel();
        chk_cr("rb_one", 2, 0, 8, 1, 4);
        put(mk(LW, LS, 32'h310), mk(ADD, AL, 32'h314));
        step();
        chk_out("rb_part", LW, UNKNOWN, 1'b1);
        chk_cr("rb_part", 2, 0, 7, 0, 4);
        step();
        chk_out("rb_hold", UNKNOWN, UNKNOWN, 1'b1);
        chk_cr("rb_hold", 2, 0, 7, 0, 4);

        // Flush with hold live, a release and a bundle present: all dropped.
        flush = 1'b1;
        rel[int'(LS)] = 2'd2;
        put(mk(ADD, AL, 32'h320), mk(BEQ, BR, 32'h324));
        step();
        flush = 1'b0;
        clear_rel();
        put(e, e);
        chk_out("flush", UNKNOWN, UNKNOWN, 1'b0);
        chk_cr("flush", 8, 4, 8, 32, 4);
        step();
        chk_out("post_flush", UNKNOWN, UNKNOWN, 1'b0);
        chk_cr("post_flush", 8, 4, 8, 32, 4);

        // Reset together with flush in the middle of a stall.
        put(mk(BEQ, BR, 32'h330), mk(BEQ, BR, 32'h334));
        step();
        step();
        put(mk(BEQ, BR, 32'h338), mk(ADD, AL, 32'h33c));
        step();
        chk_out("stall2", UNKNOWN, UNKNOWN, 1'b1);
        reset = 1'b1;
        flush = 1'b1;
        step();
        reset = 1'b0;
        flush = 1'b0;
        chk_out("rst_mid", UNKNOWN, UNKNOWN, 1'b0);
        chk("rst_mid.addr0", 64'(outs[0].address), 64'h0);
        chk_cr("rst_mid", 8, 4, 8, 32, 4);
        put(mk(ADD, AL, 32'h340), mk(BEQ, BR, 32'h344));
        step();
        chk_out("after_rst", ADD, BEQ, 1'b0);
        chk_cr("after_rst", 7, 3, 8, 30, 4);

        // Empty way 0 does not block way 1.
        put(e, mk(ADD, AL, 32'h400));
        step();
        put(e, e);
        chk_out("gap", UNKNOWN, ADD, 1'b0);
        chk("gap.addr1", 64'(outs[1].address), 64'h400);
        chk_cr("gap", 6, 3, 8, 29, 4);
        step();
        chk_out("idle", UNKNOWN, UNKNOWN, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
